// File: rtl/score_display_if.sv
// rtl/score_display_if.sv - score input, BCD result and 7-segment drive bundle
interface score_display_if;
  logic [10:0] count;
  logic [15:0] bcd;
  logic        busy;
  logic [3:0]  an;
  logic [7:0]  seg;

  modport master (output count, input bcd, input busy, input an, input seg);
  modport slave  (input count, output bcd, output busy, output an, output seg);
endinterface

// File: rtl/score_display.sv
// rtl/score_display.sv - sequential double-dabble score converter driving a muxed 4-digit display
module score_display #(
  parameter int REFRESH_BITS  = 18,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  score_display_if.slave  sd
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_nx;
  logic [10:0] last_count, last_count_nx;
  logic [26:0] work, work_nx;
  logic [26:0] adj;
  logic [3:0]  iter, iter_nx;
  logic [15:0] bcd_q, bcd_nx;
  logic        busy_q, busy_nx;

  logic [REFRESH_BITS-1:0] scan;
  logic [1:0]  sel;
  logic [3:0]  digit;
  logic        blank;
  logic [6:0]  glyph;
  logic [3:0]  an_q;
  logic [7:0]  seg_q;

  // Add-3 correction on every BCD nibble that would overflow past 9 after the shift.
  always_comb begin
    adj = work;
    for (int i = 0; i < 4; i++) begin
      if (work[11 + 4*i +: 4] >= 4'd5)
        adj[11 + 4*i +: 4] = work[11 + 4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_nx      = state;
    last_count_nx = last_count;
    work_nx       = work;
    iter_nx       = iter;
    bcd_nx        = bcd_q;
    busy_nx       = busy_q;
    case (state)
      IDLE: begin
        if (sd.count != last_count) begin
          last_count_nx = sd.count;
          work_nx       = {16'b0, sd.count};
          iter_nx       = 4'd0;
          busy_nx       = 1'b1;
          state_nx      = SHIFT;
        end
      end
      SHIFT: begin
        work_nx = adj << 1;
        iter_nx = iter + 4'd1;
        if (iter == 4'd10)
          state_nx = DONE;
      end
      DONE: begin
        bcd_nx   = work[26:11];
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_count <= 11'd0;
      work       <= 27'd0;
      iter       <= 4'd0;
      bcd_q      <= 16'd0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_nx;
      last_count <= last_count_nx;
      work       <= work_nx;
      iter       <= iter_nx;
      bcd_q      <= bcd_nx;
      busy_q     <= busy_nx;
    end
  end

  assign sel = scan[REFRESH_BITS-1 -: 2];

  always_comb begin
    digit = bcd_q[4*sel +: 4];
    case (sel)
      2'd3:    blank = (bcd_q[15:12] == 4'd0);
      2'd2:    blank = (bcd_q[15:8]  == 8'd0);
      2'd1:    blank = (bcd_q[15:4]  == 12'd0);
      default: blank = 1'b0;
    endcase
    if (!BLANK_LEADING)
      blank = 1'b0;
    case (digit)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = 7'b1111111;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan  <= '0;
      an_q  <= 4'hF;
      seg_q <= 8'hFF;
    end else begin
      scan  <= scan + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
      an_q  <= ~(4'b0001 << sel);
      seg_q <= blank ? 8'hFF : {1'b1, glyph};
    end
  end

  assign sd.bcd  = bcd_q;
  assign sd.busy = busy_q;
  assign sd.an   = an_q;
  assign sd.seg  = seg_q;

endmodule

// File: tb/tb_score_display.sv
// tb/tb_score_display.sv - table, hand-sequence and random checks of score_display
module tb_score_display;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  score_display_if sd1 ();
  score_display_if sd0 ();

  score_display #(.REFRESH_BITS(4), .BLANK_LEADING(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .sd  (sd1)
  );

  score_display #(.REFRESH_BITS(4), .BLANK_LEADING(1'b0)) dut_nb (
    .clk (clk),
    .rst (rst),
    .sd  (sd0)
  );

  localparam logic [7:0] SEG_TAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  localparam int P10 [4] = '{1, 10, 100, 1000};

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [15:0] bcd_of(int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // A digit is dark when the whole value is below its place weight.
  function automatic logic [7:0] disp(int v, int s, bit blank_en);
    if (blank_en && s != 0 && v < P10[s])
      return 8'hFF;
    return SEG_TAB[(v / P10[s]) % 10];
  endfunction

  // Reference: a conversion holds its captured value for 12 edges, then publishes it.
  int         m_val, m_pend, m_last, m_rem, m_scan;
  logic       m_busy;
  logic [3:0] m_an;
  logic [7:0] m_seg1, m_seg0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_val  <= 0;
      m_pend <= 0;
      m_last <= 0;
      m_rem  <= 0;
      m_scan <= 0;
      m_busy <= 1'b0;
      m_an   <= 4'hF;
      m_seg1 <= 8'hFF;
      m_seg0 <= 8'hFF;
    end else begin
      m_an   <= ~(4'b0001 << (m_scan / 4));
      m_seg1 <= disp(m_val, m_scan / 4, 1'b1);
      m_seg0 <= disp(m_val, m_scan / 4, 1'b0);
      m_scan <= (m_scan + 1) % 16;
      if (m_rem == 0) begin
        if (int'(sd1.count) != m_last) begin
          m_last <= int'(sd1.count);
          m_pend <= int'(sd1.count);
          m_rem  <= 12;
          m_busy <= 1'b1;
        end
      end else begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_val  <= m_pend;
          m_busy <= 1'b0;
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_count(int v);
    sd1.count = 11'(v);
    sd0.count = 11'(v);
  endtask

  task automatic tick();
    @(negedge clk);
    chk("bcd",    32'(sd1.bcd),  32'(bcd_of(m_val)));
    chk("busy",   32'(sd1.busy), 32'(m_busy));
    chk("an",     32'(sd1.an),   32'(m_an));
    chk("seg",    32'(sd1.seg),  32'(m_seg1));
    chk("bcd_nb", 32'(sd0.bcd),  32'(bcd_of(m_val)));
    chk("an_nb",  32'(sd0.an),   32'(m_an));
    chk("seg_nb", 32'(sd0.seg),  32'(m_seg0));
  endtask

  task automatic wait_busy(logic lvl, int bound, string name);
    int n = 0;
    while (sd1.busy !== lvl && n < bound) begin
      tick();
      n++;
    end
    chk(name, 32'(sd1.busy), 32'(lvl));
  endtask

  task automatic digit_seg(int d, output logic [7:0] s1, output logic [7:0] s0);
    logic [3:0] want;
    int n = 0;
    want = ~(4'b0001 << d);
    while (sd1.an !== want && n < 40) begin
      tick();
      n++;
    end
    chk("an_scan", 32'(sd1.an), 32'(want));
    s1 = sd1.seg;
    s0 = sd0.seg;
  endtask

  typedef struct {
    int               cnt;
    logic [15:0]      bcd;
    logic [3:0][7:0]  seg;
  } vec_t;

  vec_t tab [9];

  initial begin
    logic [7:0] s1, s0;
    logic       saw_busy;
    int         n;

    tab[0] = '{1234, 16'h1234, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
    tab[1] = '{2047, 16'h2047, {8'hA4, 8'hC0, 8'h99, 8'hF8}};
    tab[2] = '{7,    16'h0007, {8'hFF, 8'hFF, 8'hFF, 8'hF8}};
    tab[3] = '{999,  16'h0999, {8'hFF, 8'h90, 8'h90, 8'h90}};
    tab[4] = '{40,   16'h0040, {8'hFF, 8'hFF, 8'h99, 8'hC0}};
    tab[5] = '{1000, 16'h1000, {8'hF9, 8'hC0, 8'hC0, 8'hC0}};
    tab[6] = '{2006, 16'h2006, {8'hA4, 8'hC0, 8'hC0, 8'h82}};
    tab[7] = '{1858, 16'h1858, {8'hF9, 8'h80, 8'h92, 8'h80}};
    tab[8] = '{0,    16'h0000, {8'hFF, 8'hFF, 8'hFF, 8'hC0}};

    set_count(0);
    tick();
    chk("rst_bcd",  32'(sd1.bcd),  32'h0);
    chk("rst_busy", 32'(sd1.busy), 32'h0);
    chk("rst_an",   32'(sd1.an),   32'hF);
    chk("rst_seg",  32'(sd1.seg),  32'hFF);
    tick();
    rst = 1'b1;

    saw_busy = 1'b0;
    repeat (24) begin
      tick();
      if (sd1.busy) saw_busy = 1'b1;
    end
    chk("zero_no_busy", 32'(saw_busy), 32'h0);

    for (int i = 0; i < 9; i++) begin
      set_count(tab[i].cnt);
      n = 0;
      tick();
      while (sd1.busy === 1'b1 && n < 30) begin
        n++;
        tick();
      end
      chk("busy_cycles", 32'(n), (i == 0 || tab[i].cnt != tab[i-1].cnt) ? 32'd12 : 32'd0);
      chk("tab_bcd", 32'(sd1.bcd), 32'(tab[i].bcd));
      tick();
      tick();
      for (int d = 3; d >= 0; d--) begin
        digit_seg(d, s1, s0);
        chk("tab_seg", 32'(s1), 32'(tab[i].seg[d]));
        if (tab[i].cnt == 40 && d == 3)
          chk("noblank_thousands", 32'(s0), 32'hC0);
        if (tab[i].cnt == 40 && d == 1)
          chk("noblank_tens", 32'(s0), 32'h99);
      end
    end

    set_count(5);
    tick();
    set_count(6);
    tick();
    set_count(7);
    wait_busy(1'b0, 30, "step_first_done");
    chk("step_first_bcd", 32'(sd1.bcd), 32'h0005);
    tick();
    chk("step_restart_busy", 32'(sd1.busy), 32'h1);
    wait_busy(1'b0, 30, "step_second_done");
    chk("step_second_bcd", 32'(sd1.bcd), 32'h0007);

    set_count(999);
    tick();
    tick();
    tick();
    chk("mid_busy_before_rst", 32'(sd1.busy), 32'h1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_bcd",  32'(sd1.bcd),  32'h0);
    chk("arst_busy", 32'(sd1.busy), 32'h0);
    chk("arst_an",   32'(sd1.an),   32'hF);
    chk("arst_seg",  32'(sd1.seg),  32'hFF);
    tick();
    rst = 1'b1;
    wait_busy(1'b1, 4, "rerun_start");
    wait_busy(1'b0, 30, "rerun_done");
    chk("rerun_bcd", 32'(sd1.bcd), 32'h0999);

    repeat (300) begin
      set_count($urandom_range(0, 2047));
      repeat ($urandom_range(1, 20)) tick();
    end
    repeat (14) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
